// File: rtl/mcp_rx_arbiter.sv
// Receive endpoint for toggle-request MCP channels: synchronise each request, capture its word,
// and merge all channels onto one valid/ready stream with round-robin arbitration.
// Optional overrun detection is built when MCP_RX_OVERRUN_DET_EN is defined.
module mcp_rx_arbiter #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int NUM_CH      = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_tgl,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]            ack_tgl,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [CH_W-1:0]              m_ch,
  input  logic                         m_ready,
  output logic [NUM_CH-1:0]            overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_OUT  = 2'd2
  } ch_state_e;

  logic [NUM_CH-1:0]     sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]     edge_q;
  logic [NUM_CH-1:0]     evt_s;
  ch_state_e             state_q [NUM_CH];
  ch_state_e             state_d [NUM_CH];
  logic [DATA_WIDTH-1:0] hold_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] hold_d  [NUM_CH];
  logic [NUM_CH-1:0]     ack_q, ack_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [CH_W-1:0]       m_ch_q, m_ch_d;
  logic [CH_W-1:0]       last_grant_q, last_grant_d;
  logic                  hi_valid_s, lo_valid_s, grant_valid_s;
  logic [CH_W-1:0]       hi_grant_s, lo_grant_s, grant_s;
  logic                  accept_s, load_s;

  // Request toggle synchronisers followed by the edge register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= {NUM_CH{1'b0}};
      edge_q <= {NUM_CH{1'b0}};
    end else begin
      sync_q[0] <= req_tgl;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt_s = sync_q[SYNC_STAGES-1] ^ edge_q;

  // Round-robin pick: lowest pending channel above last_grant, else lowest pending overall.
  always_comb begin
    hi_valid_s = 1'b0;
    lo_valid_s = 1'b0;
    hi_grant_s = {CH_W{1'b0}};
    lo_grant_s = {CH_W{1'b0}};
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (state_q[c] == ST_PEND) begin
        if (CH_W'(c) > last_grant_q) begin
          hi_valid_s = 1'b1;
          hi_grant_s = CH_W'(c);
        end else begin
          lo_valid_s = 1'b1;
          lo_grant_s = CH_W'(c);
        end
      end else begin
        hi_valid_s = hi_valid_s;
      end
    end
    grant_valid_s = hi_valid_s | lo_valid_s;
    grant_s       = hi_valid_s ? hi_grant_s : lo_grant_s;
  end

  assign accept_s = m_valid_q & m_ready;
  assign load_s   = (~m_valid_q | m_ready) & grant_valid_s;

  // Per-channel state, capture, ack and output-register next state.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    ack_d        = ack_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_ch_d       = m_ch_q;
    last_grant_d = last_grant_q;
    for (int c = 0; c < NUM_CH; c++) begin
      // A request seen outside IDLE is an overrun; it is simply ignored here.
      case (state_q[c])
        ST_IDLE: begin
          if (evt_s[c]) begin
            hold_d[c]  = req_data[c*DATA_WIDTH +: DATA_WIDTH];
            state_d[c] = ST_PEND;
          end else begin
            state_d[c] = ST_IDLE;
          end
        end
        ST_PEND: begin
          if (load_s && (grant_s == CH_W'(c))) begin
            state_d[c] = ST_OUT;
          end else begin
            state_d[c] = ST_PEND;
          end
        end
        ST_OUT: begin
          if (accept_s && (m_ch_q == CH_W'(c))) begin
            state_d[c] = ST_IDLE;
            ack_d[c]   = ~ack_q[c];
          end else begin
            state_d[c] = ST_OUT;
          end
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
    if (load_s) begin
      m_valid_d    = 1'b1;
      m_data_d     = hold_q[grant_s];
      m_ch_d       = grant_s;
      last_grant_d = grant_s;
    end else if (accept_s) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State, hold and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        hold_q[c]  <= {DATA_WIDTH{1'b0}};
      end
      ack_q        <= {NUM_CH{1'b0}};
      m_valid_q    <= 1'b0;
      m_data_q     <= {DATA_WIDTH{1'b0}};
      m_ch_q       <= {CH_W{1'b0}};
      last_grant_q <= CH_W'(NUM_CH - 1);
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      ack_q        <= ack_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_ch_q       <= m_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign ack_tgl = ack_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_ch    = m_ch_q;

`ifdef MCP_RX_OVERRUN_DET_EN
  logic [NUM_CH-1:0] overrun_q;
  logic [NUM_CH-1:0] ovr_evt_s;

  // Flag a new request arriving while the previous word is still in flight.
  always_comb begin
    ovr_evt_s = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      ovr_evt_s[c] = evt_s[c] & (state_q[c] != ST_IDLE);
    end
  end

  // Sticky overrun flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= {NUM_CH{1'b0}};
    end else begin
      overrun_q <= overrun_q | ovr_evt_s;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = {NUM_CH{1'b0}};
`endif

endmodule

// File: tb/tb_mcp_rx_arbiter.sv
// Scoreboard bench for mcp_rx_arbiter: expected words are queued as requests are toggled
// and compared in order as the stream accepts them.
module tb_mcp_rx_arbiter;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int CW  = 2;
`ifdef MCP_RX_OVERRUN_DET_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req_tgl;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    ack_tgl;
  logic              m_valid;
  logic [DW-1:0]     m_data;
  logic [CW-1:0]     m_ch;
  logic              m_ready;
  logic [NCH-1:0]    overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW+DW-1:0] sb_q[$];
  logic [CW+DW-1:0] exp_w;
  logic [NCH-1:0]   exp_ack;

  mcp_rx_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NCH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .req_tgl(req_tgl), .req_data(req_data), .ack_tgl(ack_tgl),
    .m_valid(m_valid), .m_data(m_data), .m_ch(m_ch), .m_ready(m_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c, input logic [DW-1:0] d);
    req_data[c*DW +: DW] = d;
    req_tgl[c] = ~req_tgl[c];
    sb_q.push_back({CW'(c), d});
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_tgl = '0;
    req_data = '0;
    m_ready = 1'b0;
    sb_q.delete();
    exp_ack = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", m_data); end
    n_checks++; if (m_ch !== '0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", m_ch); end
    n_checks++; if (ack_tgl !== '0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack_tgl); end
    n_checks++; if (overrun !== '0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0000", overrun); end
  endtask

  task automatic test_single();
    bit seen = 1'b0;
    m_ready = 1'b1;
    send(2, 32'hA5A5_0001);
    for (int e = 1; e <= 8 && !seen; e++) begin
      tick();
      if (m_valid) begin
        seen = 1'b1;
        exp_w = sb_q.pop_front();
        n_checks++; if (e != 4) begin n_fail++; $display("FAIL single_latency: got edge %0d want edge 4", e); end
        n_checks++; if ({m_ch, m_data} !== exp_w) begin n_fail++; $display("FAIL single_word: got ch=%0d data=%h want ch=%0d data=%h", m_ch, m_data, exp_w[DW +: CW], exp_w[DW-1:0]); end
        n_checks++; if (ack_tgl !== exp_ack) begin n_fail++; $display("FAIL single_ack_early: got %b want %b", ack_tgl, exp_ack); end
        exp_ack[exp_w[DW +: CW]] = ~exp_ack[exp_w[DW +: CW]];
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL single_timeout: got no m_valid want one word"); end
    tick();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got m_valid=%b want 0", m_valid); end
    n_checks++; if (ack_tgl !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", ack_tgl); end
  endtask

  task automatic test_round_robin();
    int first_cyc;
    int k;
    for (int run = 0; run < 2; run++) begin
      if (run == 0) begin
        apply_reset();
      end else begin
        send(1, 32'h0000_0021);
        for (int cyc = 0; cyc < 12 && sb_q.size() > 0; cyc++) begin
          if (m_valid && m_ready) begin
            exp_w = sb_q.pop_front();
            n_checks++; if ({m_ch, m_data} !== exp_w) begin n_fail++; $display("FAIL rr_prime: got ch=%0d data=%h want ch=%0d data=%h", m_ch, m_data, exp_w[DW +: CW], exp_w[DW-1:0]); end
            exp_ack[exp_w[DW +: CW]] = ~exp_ack[exp_w[DW +: CW]];
          end
          tick();
        end
      end
      m_ready = 1'b1;
      for (int j = 0; j < NCH; j++) send((j + 2*run) % NCH, 32'h10 + ((j + 2*run) % NCH));
      k = 0;
      first_cyc = -1;
      for (int cyc = 0; cyc < 20 && sb_q.size() > 0; cyc++) begin
        if (m_valid && m_ready) begin
          exp_w = sb_q.pop_front();
          if (first_cyc < 0) first_cyc = cyc;
          n_checks++;
          if ({m_ch, m_data} !== exp_w || cyc != first_cyc + k) begin
            n_fail++;
            $display("FAIL rr_order run%0d: got ch=%0d data=%h cycle=%0d want ch=%0d data=%h cycle=%0d", run, m_ch, m_data, cyc, exp_w[DW +: CW], exp_w[DW-1:0], first_cyc + k);
          end
          exp_ack[exp_w[DW +: CW]] = ~exp_ack[exp_w[DW +: CW]];
          k++;
        end
        tick();
      end
      n_checks++; if (sb_q.size() != 0 || ack_tgl !== exp_ack) begin n_fail++; $display("FAIL rr_done run%0d: got pending=%0d ack=%b want pending=0 ack=%b", run, sb_q.size(), ack_tgl, exp_ack); end
    end
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    int first_cyc = -1;
    int k = 0;
    apply_reset();
    m_ready = 1'b0;
    send(0, 32'hB000_0000);
    send(3, 32'hB000_0003);
    for (int e = 0; e < 10 && !seen; e++) begin
      tick();
      seen = m_valid;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_timeout: got no m_valid want ch0 word"); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_ch !== 2'd0 || m_data !== 32'hB000_0000 || ack_tgl !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got v=%b ch=%0d data=%h ack=%b want v=1 ch=0 data=b0000000 ack=0000", i, m_valid, m_ch, m_data, ack_tgl);
      end
      tick();
    end
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && sb_q.size() > 0; cyc++) begin
      if (m_valid && m_ready) begin
        exp_w = sb_q.pop_front();
        if (first_cyc < 0) first_cyc = cyc;
        n_checks++;
        if ({m_ch, m_data} !== exp_w || cyc != first_cyc + k) begin
          n_fail++;
          $display("FAIL bp_drain: got ch=%0d data=%h cycle=%0d want ch=%0d data=%h cycle=%0d", m_ch, m_data, cyc, exp_w[DW +: CW], exp_w[DW-1:0], first_cyc + k);
        end
        exp_ack[exp_w[DW +: CW]] = ~exp_ack[exp_w[DW +: CW]];
        k++;
      end
      tick();
    end
    n_checks++; if (sb_q.size() != 0 || ack_tgl !== 4'b1001) begin n_fail++; $display("FAIL bp_done: got pending=%0d ack=%b want pending=0 ack=1001", sb_q.size(), ack_tgl); end
  endtask

  task automatic test_overrun();
    bit extra = 1'b0;
    m_ready = 1'b0;
    send(1, 32'hC1C1_0001);
    repeat (3) tick();
    req_data[1*DW +: DW] = 32'hC2C2_0002;
    req_tgl[1] = ~req_tgl[1];
    repeat (4) tick();
    n_checks++; if (overrun !== (OVR_EN ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL ovr_flag: got %b want %b", overrun, OVR_EN ? 4'b0010 : 4'b0000); end
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && sb_q.size() > 0; cyc++) begin
      if (m_valid && m_ready) begin
        exp_w = sb_q.pop_front();
        n_checks++; if ({m_ch, m_data} !== exp_w) begin n_fail++; $display("FAIL ovr_word: got ch=%0d data=%h want ch=%0d data=%h", m_ch, m_data, exp_w[DW +: CW], exp_w[DW-1:0]); end
        exp_ack[exp_w[DW +: CW]] = ~exp_ack[exp_w[DW +: CW]];
      end
      tick();
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (m_valid) extra = 1'b1;
      tick();
    end
    n_checks++; if (extra || sb_q.size() != 0) begin n_fail++; $display("FAIL ovr_single_word: got extra=%b pending=%0d want extra=0 pending=0", extra, sb_q.size()); end
    n_checks++; if (ack_tgl !== 4'b1011) begin n_fail++; $display("FAIL ovr_ack: got %b want 1011", ack_tgl); end
    n_checks++; if (overrun !== (OVR_EN ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL ovr_sticky: got %b want %b", overrun, OVR_EN ? 4'b0010 : 4'b0000); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    m_ready = 1'b0;
    send(0, 32'hD000_0000);
    send(1, 32'hD000_0001);
    send(2, 32'hD000_0002);
    for (int e = 0; e < 10 && !seen; e++) begin
      tick();
      seen = m_valid;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_mid_setup: got no m_valid want word"); end
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_ch !== '0 || ack_tgl !== '0 || overrun !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got v=%b data=%h ch=%0d ack=%b ovr=%b want all 0", m_valid, m_data, m_ch, ack_tgl, overrun);
    end
    req_tgl = '0;
    sb_q.delete();
    exp_ack = '0;
    tick();
    tick();
    reset = 1'b0;
    m_ready = 1'b1;
    send(3, 32'hE3E3_0003);
    seen = 1'b0;
    for (int e = 1; e <= 8 && !seen; e++) begin
      tick();
      if (m_valid) begin
        seen = 1'b1;
        exp_w = sb_q.pop_front();
        n_checks++; if (e != 4) begin n_fail++; $display("FAIL rst_mid_latency: got edge %0d want edge 4", e); end
        n_checks++; if ({m_ch, m_data} !== exp_w) begin n_fail++; $display("FAIL rst_mid_word: got ch=%0d data=%h want ch=%0d data=%h", m_ch, m_data, exp_w[DW +: CW], exp_w[DW-1:0]); end
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_mid_timeout: got no m_valid want ch3 word"); end
    tick();
    n_checks++; if (ack_tgl !== 4'b1000 || m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack: got ack=%b v=%b want ack=1000 v=0", ack_tgl, m_valid); end
  endtask

  initial begin
    reset = 1'b1;
    req_tgl = '0;
    req_data = '0;
    m_ready = 1'b0;
    exp_ack = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mcp_rx_arbiter.md
# mcp_rx_arbiter

Receive-side endpoint for multi-cycle-path (MCP) transfers. It serves NUM_CH independent toggle-request/data channels launched from foreign clock domains. Each channel's request toggle is synchronised into clk, its held data word is captured, and the captured words are merged onto one valid/ready stream through a round-robin arbiter. A per-channel ack toggle is returned when the word is accepted. It sits at the clk boundary of a multi-source MCP fabric, in place of per-channel receive logic.

## Interface
- DATA_WIDTH, 32: width of each channel's data word
- NUM_CH, 4: number of request channels, ≥1
- SYNC_STAGES, 2: synchroniser flops per request toggle, ≥2
- CH_W, derived: $clog2(NUM_CH), minimum 1

Ports:
- clk  in  1  receive clock, the only clock of the block
- reset  in  1  asynchronous, active-high; clears all state
- req_tgl  in  NUM_CH  per-channel request toggle, asynchronous to clk; one transition = one word
- req_data  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]; held stable by the sender from its toggle until the matching ack
- ack_tgl  out  NUM_CH  per-channel acknowledge toggle, registered, for synchronisation by the sender
- m_valid  out  1  output word valid
- m_data  out  DATA_WIDTH  output word
- m_ch  out  CH_W  source channel of m_data
- m_ready  in  1  consumer ready
- overrun  out  NUM_CH  sticky per-channel protocol-violation flag (see Configuration)

## Operation
- Per channel: SYNC_STAGES-flop chain on req_tgl[c], then one edge-register. evt[c] = sync_out ^ edge_reg.
- Per-channel state: IDLE → PEND → OUT → IDLE.
  - IDLE: on evt, capture req_data slice into hold[c] and go to PEND.
  - PEND: wait for grant.
  - OUT: word is in the output register. Leave on m_valid && m_ready && m_ch==c; ack_tgl[c] flips on that same edge.
- Output register loads when !m_valid || m_ready, provided any channel is PEND. On load: m_data ← hold[g], m_ch ← g, m_valid ← 1, channel g → OUT.
- Accept and reload in the same cycle is allowed, giving back-to-back words with no bubble.
- Arbiter: round-robin over PEND channels. Search starts at last_grant+1 modulo NUM_CH; last_grant updates on each load.
- m_valid deasserts only on accept with no PEND channel. m_data and m_ch hold while m_valid && !m_ready.
- evt on a channel in PEND or OUT is an overrun: the new word is discarded, hold[c] and the state are unchanged, and no ack is generated.

## Timing
- Reset values: m_valid=0, m_data=0, m_ch=0, ack_tgl=0, overrun=0, all sync/edge flops 0, last_grant=NUM_CH-1 (so channel 0 wins first), all channels IDLE.
- Latency with the arbiter free: first clk edge sampling the new req_tgl level is edge 1. evt is high after edge SYNC_STAGES, hold loads on edge SYNC_STAGES+1, m_valid rises on edge SYNC_STAGES+2 (edge 4 for default).
- ack_tgl[c] changes on the accepting edge. The sender sees it after its own synchroniser.
- Simultaneous evts on several channels: all captured on the same edge, then emitted in round-robin order, one word per accepted cycle.
- Single channel throughput: one word per ack round trip. The block never limits a channel's rate below that.
- Reset asserted mid-transfer: all state clears immediately, held and in-flight words are lost, and ack_tgl returns to 0. Senders must be reset with this block.

## Configuration
- MCP_RX_OVERRUN_DET_EN defined: overrun[c] sets on the edge after an overrun evt and stays set until reset.
- MCP_RX_OVERRUN_DET_EN undefined: overrun is tied to 0 and no detect logic is built. Data-path behaviour is identical in both builds, including discarding the violating word.

## Test plan
- Single word: NUM_CH=4, SYNC_STAGES=2, m_ready=1, toggle req_tgl[2] with req_data ch2=32'hA5A5_0001 → m_valid on edge 4 with m_data=32'hA5A5_0001, m_ch=2, one-cycle valid, ack_tgl[2] flips 0→1 on the same edge.
- Round robin: toggle all four channels in the same cycle with data 0x10..0x13, m_ready=1 → words on four consecutive cycles in order ch0,1,2,3. Repeat with the first grant at ch1 → order 2,3,0,1.
- Backpressure: m_ready=0 for 10 cycles with ch0 and ch3 pending → m_data/m_ch stable at ch0. ack_tgl unchanged until m_ready=1, then ch0 and ch3 are accepted back-to-back.
- Overrun: toggle req_tgl[1] twice before its ack → one word out with the first data, a single ack flip, and overrun[1]=1 with MCP_RX_OVERRUN_DET_EN defined (0 without).
- Reset mid-operation: assert reset while m_valid=1 with two channels pending → all outputs 0 asynchronously. After release, a fresh toggle is delivered with normal latency.
